sc_coin_ctrl: RTL and testbench
===============================

# sc_coin_ctrl

Control stage directly upstream of the coin-type register. It drives the register's active-low clear (spawn a coin) and load (take a coin) strobes and compares frog and coin grid positions to detect a pickup. It also runs a tick-based respawn cooldown and keeps an optional saturating pickup score. It sits between the frog/coin position logic and the coin-type register; the register's output is fed back as the coin-present input.

## Interface
Parameters:
- POS_WIDTH, 4: width of each grid coordinate.
- COOLDOWN_TICKS, 8: game ticks between a pickup and the next spawn; legal range 1..255.
- SCORE_WIDTH, 8: width of the pickup score.

Ports:
- SC_RegCOINTYPE_CLOCK_50, in, 1: system clock, 50 MHz.
- SC_RegCOINTYPE_RESET_InHigh, in, 1: reset, asynchronous, active-high.
- SC_CoinCtrl_start_InHigh, in, 1: one-cycle pulse that starts coin play.
- SC_CoinCtrl_stop_InHigh, in, 1: level; forces IDLE.
- SC_CoinCtrl_tick_InHigh, in, 1: one-cycle game-tick strobe.
- SC_CoinCtrl_frogX, in, POS_WIDTH: frog column.
- SC_CoinCtrl_frogY, in, POS_WIDTH: frog row.
- SC_CoinCtrl_coinX, in, POS_WIDTH: coin column.
- SC_CoinCtrl_coinY, in, POS_WIDTH: coin row.
- SC_CoinCtrl_coinPresent_In, in, 1: coin-type register output; 1 = coin present.
- SC_CoinCtrl_clear_OutLow, out, 1: to the register clear input; 0 for one cycle = spawn.
- SC_CoinCtrl_load_OutLow, out, 1: to the register load input; 0 for one cycle = take.
- SC_CoinCtrl_collected_OutHigh, out, 1: one-cycle pickup pulse.
- SC_CoinCtrl_score_Out, out, SCORE_WIDTH: pickup count.

## Operation
- FSM states: IDLE, SPAWN, ARMED, COLLECT, COOLDOWN. All outputs are decoded from the state register, so they are glitch-free.
- IDLE: both strobes 1 and collected 0. A start pulse moves the FSM to SPAWN.
- SPAWN: clear_OutLow=0 for exactly one cycle, then ARMED.
- ARMED: when coinPresent=1 and frogX==coinX and frogY==coinY, go to COLLECT. Otherwise stay.
- COLLECT: load_OutLow=0 and collected=1 for exactly one cycle. On the exit edge:
  - score increments, saturating at all-ones;
  - cooldown counter loads COOLDOWN_TICKS;
  - next state is COOLDOWN.
- COOLDOWN:
  - each tick decrements the counter;
  - the tick that takes the counter from 1 to 0 moves the FSM to SPAWN;
  - position matches are ignored.
- stop=1 in any state forces IDLE on the next edge. stop has priority over start, tick and match. Score and counter hold.
- A start pulse outside IDLE is ignored.
- clear_OutLow and load_OutLow are never 0 in the same cycle.
- The match compare is full-width unsigned equality. There is no wrap-around arithmetic on positions.

## Timing
- Reset values: state=IDLE, clear_OutLow=1, load_OutLow=1, collected_OutHigh=0, score=0, counter=0.
- Start sampled at edge E: SPAWN during E..E+1. The register shows coin present from after edge E+1.
- Match sampled at edge M: COLLECT during M..M+1. The register shows 0 and the new score is visible after edge M+1.
- Match-to-strobe latency is 1 cycle.
- The cooldown spans exactly COOLDOWN_TICKS tick pulses. A tick in the COLLECT cycle is not counted.
- Reset mid-operation: immediate return to the reset values. The register is reset by the same signal.
- A match already true on entry to ARMED is taken on the first ARMED edge. The one-cycle delay before the register updates guarantees a single pickup per spawn.

## Configuration
- SC_COINCTRL_SCORE_EN defined: the score counter and saturation logic are compiled in.
- SC_COINCTRL_SCORE_EN undefined: score_Out is tied to 0 and no score flops exist. The FSM, strobes and collected pulse are unchanged.

## Structure
- Shared package/include file sc_coin_pkg:
  - state encoding constants (IDLE=0, SPAWN=1, ARMED=2, COLLECT=3, COOLDOWN=4; 3-bit);
  - COOLDOWN counter width constant (8).
- One sub-module, sc_coin_cooldown: loadable 8-bit down-counter with a tick enable and a registered zero-reached flag.
- The FSM and score counter live in the top module.

## Test plan
- Reset asserted mid-COOLDOWN with score=3 -> all outputs at reset values immediately; state IDLE; score=0.
- Start, then positions (5,7)/(5,7) with coinPresent=1 -> clear low 1 cycle; load low exactly 1 cycle the cycle after the match; score 0->1.
- After a pickup with COOLDOWN_TICKS=3 and ticks every 10 cycles -> next clear_OutLow low occurs one cycle after the 3rd tick; no earlier strobe.
- Frog held on the coin for 50 cycles -> exactly one collected pulse per spawn.
- stop raised in the same cycle as a match in ARMED -> no load strobe; state IDLE; score unchanged.
- SCORE_WIDTH=2 with 5 pickups -> score saturates at 3. With SC_COINCTRL_SCORE_EN undefined -> score stays 0 and the strobes are identical.

Source files
------------

// File: rtl/sc_coin_pkg.sv
// ---------------------------------------------------------------------------
// sc_coin_pkg
// Shared definitions for the coin control stage: FSM state encoding,
// cooldown counter width and a helper that clamps the cooldown reload value
// into the counter's usable 1..255 range.
// ---------------------------------------------------------------------------
package sc_coin_pkg;

    localparam int CD_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPAWN    = 3'd1,
        ST_ARMED    = 3'd2,
        ST_COLLECT  = 3'd3,
        ST_COOLDOWN = 3'd4
    } coin_state_e;

    // A zero reload would never expire through a tick, so clamp to 1..255.
    function automatic logic [CD_WIDTH-1:0] cd_load_value(input int ticks);
        if (ticks < 1)
            return CD_WIDTH'(1);
        else if (ticks > 255)
            return CD_WIDTH'(255);
        else
            return ticks[CD_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sc_coin_cooldown.sv
// ---------------------------------------------------------------------------
// sc_coin_cooldown
// Loadable down-counter that times the gap between a pickup and the next
// coin spawn, counted in game ticks.
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   load_i      load load_val_i into the counter (wins over tick_i)
//   load_val_i  reload value
//   tick_i      decrement enable (already qualified by the caller)
//   zero_o      registered flag, counter currently holds zero
//   expire_o    this tick takes the counter from 1 to 0
// ---------------------------------------------------------------------------
module sc_coin_cooldown
    import sc_coin_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [CD_WIDTH-1:0] load_val_i,
    input  logic                tick_i,
    output logic                zero_o,
    output logic                expire_o
);

    logic [CD_WIDTH-1:0] cnt_q, cnt_d;
    logic                zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (tick_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    // Expiry is seen on the same edge as the final tick so the spawn strobe
    // follows that tick by exactly one cycle.
    assign expire_o = tick_i && !load_i && (cnt_q == CD_WIDTH'(1));
    assign zero_o   = zero_q;

endmodule

// File: rtl/sc_coin_ctrl.sv
// ---------------------------------------------------------------------------
// sc_coin_ctrl
// Control stage in front of the coin-type register. Spawns a coin (active-low
// clear strobe), detects the frog landing on a present coin, takes it
// (active-low load strobe, collected pulse), then waits a tick-based cooldown
// before spawning again. An optional saturating pickup score is kept.
//
// Build option: define SC_COINCTRL_SCORE_EN to compile in the score counter;
// otherwise SC_CoinCtrl_score_Out is tied to zero.
//
// Ports:
//   SC_RegCOINTYPE_CLOCK_50        system clock
//   SC_RegCOINTYPE_RESET_InHigh    asynchronous active-high reset
//   SC_CoinCtrl_start_InHigh       start pulse (honoured only in IDLE)
//   SC_CoinCtrl_stop_InHigh        level, forces IDLE, highest priority
//   SC_CoinCtrl_tick_InHigh        game-tick strobe for the cooldown
//   SC_CoinCtrl_frogX/frogY        frog grid position
//   SC_CoinCtrl_coinX/coinY        coin grid position
//   SC_CoinCtrl_coinPresent_In     coin-type register output, 1 = coin present
//   SC_CoinCtrl_clear_OutLow       spawn strobe to register clear
//   SC_CoinCtrl_load_OutLow        take strobe to register load
//   SC_CoinCtrl_collected_OutHigh  one-cycle pickup pulse
//   SC_CoinCtrl_score_Out          pickup count
// ---------------------------------------------------------------------------
module sc_coin_ctrl
    import sc_coin_pkg::*;
#(
    parameter int POS_WIDTH      = 4,
    parameter int COOLDOWN_TICKS = 8,
    parameter int SCORE_WIDTH    = 8
) (
    input  logic                   SC_RegCOINTYPE_CLOCK_50,
    input  logic                   SC_RegCOINTYPE_RESET_InHigh,
    input  logic                   SC_CoinCtrl_start_InHigh,
    input  logic                   SC_CoinCtrl_stop_InHigh,
    input  logic                   SC_CoinCtrl_tick_InHigh,
    input  logic [POS_WIDTH-1:0]   SC_CoinCtrl_frogX,
    input  logic [POS_WIDTH-1:0]   SC_CoinCtrl_frogY,
    input  logic [POS_WIDTH-1:0]   SC_CoinCtrl_coinX,
    input  logic [POS_WIDTH-1:0]   SC_CoinCtrl_coinY,
    input  logic                   SC_CoinCtrl_coinPresent_In,
    output logic                   SC_CoinCtrl_clear_OutLow,
    output logic                   SC_CoinCtrl_load_OutLow,
    output logic                   SC_CoinCtrl_collected_OutHigh,
    output logic [SCORE_WIDTH-1:0] SC_CoinCtrl_score_Out
);

    localparam logic [CD_WIDTH-1:0] CD_LOAD = cd_load_value(COOLDOWN_TICKS);

    coin_state_e state_q;
    logic        clear_n_q;
    logic        load_n_q;
    logic        collected_q;
    logic        match;
    logic        stop;
    logic        cd_zero;
    logic        cd_expire;

    assign stop  = SC_CoinCtrl_stop_InHigh;
    assign match = SC_CoinCtrl_coinPresent_In
                && (SC_CoinCtrl_frogX == SC_CoinCtrl_coinX)
                && (SC_CoinCtrl_frogY == SC_CoinCtrl_coinY);

    // Counter reloads on the COLLECT exit edge and only counts while cooling
    // down; stop freezes it.
    sc_coin_cooldown u_cooldown (
        .clk_i      (SC_RegCOINTYPE_CLOCK_50),
        .rst_i      (SC_RegCOINTYPE_RESET_InHigh),
        .load_i     ((state_q == ST_COLLECT) && !stop),
        .load_val_i (CD_LOAD),
        .tick_i     ((state_q == ST_COOLDOWN) && SC_CoinCtrl_tick_InHigh && !stop),
        .zero_o     (cd_zero),
        .expire_o   (cd_expire)
    );

    // Strobes are flopped alongside the state: every strobe-bearing state
    // lasts one cycle, so they default inactive and are set only on entry.
    always_ff @(posedge SC_RegCOINTYPE_CLOCK_50 or posedge SC_RegCOINTYPE_RESET_InHigh) begin
        if (SC_RegCOINTYPE_RESET_InHigh) begin
            state_q     <= ST_IDLE;
            clear_n_q   <= 1'b1;
            load_n_q    <= 1'b1;
            collected_q <= 1'b0;
        end else begin
            clear_n_q   <= 1'b1;
            load_n_q    <= 1'b1;
            collected_q <= 1'b0;
            if (stop) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (SC_CoinCtrl_start_InHigh) begin
                            state_q   <= ST_SPAWN;
                            clear_n_q <= 1'b0;
                        end
                    end
                    ST_SPAWN: state_q <= ST_ARMED;
                    ST_ARMED: begin
                        if (match) begin
                            state_q     <= ST_COLLECT;
                            load_n_q    <= 1'b0;
                            collected_q <= 1'b1;
                        end
                    end
                    ST_COLLECT: state_q <= ST_COOLDOWN;
                    ST_COOLDOWN: begin
                        // cd_zero only backs up expiry if the count is ever
                        // found empty while cooling down.
                        if (cd_expire || cd_zero) begin
                            state_q   <= ST_SPAWN;
                            clear_n_q <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign SC_CoinCtrl_clear_OutLow      = clear_n_q;
    assign SC_CoinCtrl_load_OutLow       = load_n_q;
    assign SC_CoinCtrl_collected_OutHigh = collected_q;

`ifdef SC_COINCTRL_SCORE_EN
    logic [SCORE_WIDTH-1:0] score_q, score_d;

    always_comb begin
        score_d = score_q;
        if ((state_q == ST_COLLECT) && !stop && (score_q != '1))
            score_d = score_q + 1'b1;
    end

    always_ff @(posedge SC_RegCOINTYPE_CLOCK_50 or posedge SC_RegCOINTYPE_RESET_InHigh) begin
        if (SC_RegCOINTYPE_RESET_InHigh)
            score_q <= '0;
        else
            score_q <= score_d;
    end

    assign SC_CoinCtrl_score_Out = score_q;
`else
    assign SC_CoinCtrl_score_Out = '0;
`endif

endmodule

// File: tb/tb_sc_coin_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sc_coin_ctrl
// Scoreboard bench for sc_coin_ctrl. A reference model predicts spawn and
// pickup events (with the edge they belong to) from the game rules expressed
// as timestamps and tick counts; a negedge monitor pops and compares them
// when the DUT strobes, and checks score and strobe relations every cycle.
// The coin-type register is modelled as a set/clear flop fed by the strobes.
// ---------------------------------------------------------------------------
module tb_sc_coin_ctrl;

    localparam int PW   = 4;
    localparam int CD   = 3;
    localparam int SW   = 2;
    localparam int MAXS = (1 << SW) - 1;
    localparam int EV_SPAWN = 1;
    localparam int EV_PICK  = 2;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, stop = 1'b0, tick = 1'b0, mask = 1'b0;
    logic [PW-1:0] fx = '0, fy = '0, cx = '0, cy = '0;
    logic          coin_q;
    logic          coin_in;
    logic          clear_n, load_n, collected;
    logic [SW-1:0] score;

    int  total = 0;
    int  bad   = 0;
    ev_t exp_q[$];

    // reference model state
    int  n       = 0;
    bit  live    = 0;
    int  sp      = -10;
    int  pk      = -10;
    int  tk      = 0;
    int  score_m = 0;

    bit  done       = 0;
    bit  final_done = 0;
    bit  reached    = 0;

    always #5 clk = ~clk;

    sc_coin_ctrl #(.POS_WIDTH(PW), .COOLDOWN_TICKS(CD), .SCORE_WIDTH(SW)) dut (
        .SC_RegCOINTYPE_CLOCK_50       (clk),
        .SC_RegCOINTYPE_RESET_InHigh   (rst),
        .SC_CoinCtrl_start_InHigh      (start),
        .SC_CoinCtrl_stop_InHigh       (stop),
        .SC_CoinCtrl_tick_InHigh       (tick),
        .SC_CoinCtrl_frogX             (fx),
        .SC_CoinCtrl_frogY             (fy),
        .SC_CoinCtrl_coinX             (cx),
        .SC_CoinCtrl_coinY             (cy),
        .SC_CoinCtrl_coinPresent_In    (coin_in),
        .SC_CoinCtrl_clear_OutLow      (clear_n),
        .SC_CoinCtrl_load_OutLow       (load_n),
        .SC_CoinCtrl_collected_OutHigh (collected),
        .SC_CoinCtrl_score_Out         (score)
    );

    // coin-type register: clear spawns a coin, load takes it
    always @(posedge clk or posedge rst) begin
        if (rst)          coin_q <= 1'b0;
        else if (!clear_n) coin_q <= 1'b1;
        else if (!load_n)  coin_q <= 1'b0;
    end
    assign coin_in = coin_q & ~mask;

    // Reference model: one spawn per start or per finished cooldown, one
    // pickup per spawn on the first qualifying edge two or more edges after
    // the spawn, score one edge after the pickup, ticks counted from two
    // edges after the pickup.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            live    = 0;
            score_m = 0;
            sp      = -10;
            pk      = -10;
            exp_q.delete();
        end else begin
            n++;
            if (stop) begin
                live = 0;
            end else if (!live) begin
                if (start) begin
                    live = 1;
                    sp   = n;
                    exp_q.push_back('{EV_SPAWN, n});
                end
            end else if (sp > pk) begin
                if (n >= sp + 2 && coin_in && fx == cx && fy == cy) begin
                    pk = n;
                    tk = 0;
                    exp_q.push_back('{EV_PICK, n});
                end
            end else if (n == pk + 1) begin
`ifdef SC_COINCTRL_SCORE_EN
                if (score_m < MAXS) score_m++;
`endif
            end else if (tick) begin
                tk++;
                if (tk == CD) begin
                    sp = n;
                    exp_q.push_back('{EV_SPAWN, n});
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d, t=%0t)", nm, act, req, n, $time);
        end
    endtask

    task automatic take(input int kind, input string nm);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk({"unexpected_", nm}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({nm, "_kind"}, kind, e.kind);
            chk({nm, "_edge"}, n, e.at);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_clear", int'(clear_n), 1);
            chk("rst_load", int'(load_n), 1);
            chk("rst_collected", int'(collected), 0);
            chk("rst_score", int'(score), 0);
        end else begin
            chk("strobes_exclusive", int'(!clear_n && !load_n), 0);
            chk("collected_vs_load", int'(collected), int'(!load_n));
            chk("score", int'(score), score_m);
            if (!clear_n) take(EV_SPAWN, "spawn");
            if (!load_n)  take(EV_PICK, "pick");
        end
        if (done && !final_done) begin
            chk("pending_events", exp_q.size(), 0);
            chk("cooldown_reached", int'(reached), 1);
            final_done = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset at power-up
        repeat (3) step();
        rst = 1'b0;
        step();

        // frog parked on the coin: one pickup per spawn, ticks every 10 cycles
        fx = 4'd5; fy = 4'd7; cx = 4'd5; cy = 4'd7;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            tick = (i % 10 == 9);
            step();
        end
        tick = 1'b0;

        // stop on the same edge as a match while armed
        stop = 1'b1; step(); stop = 1'b0;
        fx = 4'd1; fy = 4'd1;
        pulse_start();
        step();
        fx = 4'd5; fy = 4'd7; stop = 1'b1;
        step();
        stop = 1'b0; fx = 4'd1; fy = 4'd1;
        repeat (5) step();

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 29) == 0);
            if (stop) stop = ($urandom_range(0, 2) != 0);
            else      stop = ($urandom_range(0, 49) == 0);
            tick = ($urandom_range(0, 3) == 0);
            mask = ($urandom_range(0, 7) == 0);
            fx = PW'($urandom_range(0, 2));
            fy = PW'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) begin
                cx = PW'($urandom_range(0, 2));
                cy = PW'($urandom_range(0, 2));
            end
            step();
        end
        start = 1'b0; stop = 1'b0; tick = 1'b0; mask = 1'b0;

        // reach cooldown, then assert reset between edges
        fx = 4'd5; fy = 4'd7; cx = 4'd5; cy = 4'd7;
        pulse_start();
        for (int i = 0; i < 100 && !reached; i++) begin
            if (live && pk >= sp && n >= pk + 2) reached = 1;
            else step();
        end
        #1 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // play resumes from a cleared score
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            tick = (i % 10 == 9);
            step();
        end
        tick = 1'b0;

        done = 1;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
